// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, controller
// states, button bit positions and the opposite-direction helper.
// Reused by the direction controller, snake body and collision logic.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Bit positions inside the packed {middle, up, down, left, right} vector.
    localparam int BTN_MID   = 4;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;
    localparam int NUM_BTN   = 5;

    localparam int TURBO_W = 20;

    // Opposite direction stays on the same axis and flips the sign bit.
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button/step inputs and direction/status outputs of snake_dir_ctrl.
// master: the side driving buttons and ticks; slave: the controller.
// Optional turbo output exists only when SNAKE_DIR_TURBO_EN is defined.
interface snake_dir_ctrl_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             middle;
    logic             up;
    logic             down;
    logic             left;
    logic             right;
    logic             step;
    logic             game_over;
    logic [1:0]       dir;
    logic             dir_chg;
    logic             start;
    logic             running;
    logic             paused;
    logic [CNT_W-1:0] q_count;
    logic             drop;
`ifdef SNAKE_DIR_TURBO_EN
    logic             turbo;
`endif

    modport master (
        output middle, up, down, left, right, step, game_over,
        input  dir, dir_chg, start, running, paused, q_count, drop
`ifdef SNAKE_DIR_TURBO_EN
        , input turbo
`endif
    );

    modport slave (
        input  middle, up, down, left, right, step, game_over,
        output dir, dir_chg, start, running, paused, q_count, drop
`ifdef SNAKE_DIR_TURBO_EN
        , output turbo
`endif
    );

endinterface

// File: rtl/dir_fifo.sv
// Small synchronous FIFO for queued turn requests. Exposes both head
// (next entry to apply) and tail (most recent request) so the caller
// can validate a new request against the last queued one. A push while
// full is accepted only when a pop frees a slot in the same cycle.
module dir_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [WIDTH-1:0]           tail_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign tail_o  = mem_q[wr_ptr_q - PTR_W'(1)];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage write; entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction and run/pause controller.
// Button levels are edge-detected into registered press pulses; direction
// presses are arbitrated (up > down > left > right), checked against the
// last queued direction and queued in dir_fifo. One queued turn is applied
// per game step while running. Middle toggles IDLE->RUN->PAUSE->RUN and
// game_over returns to IDLE with the queue flushed.
// Optional feature macro: SNAKE_DIR_TURBO_EN (adds the turbo output).
//
// state    | meaning
// ST_IDLE  | waiting for middle press to start a game
// ST_RUN   | game running, turns queued and applied on step
// ST_PAUSE | game paused, direction presses and steps ignored
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter dir_t DIR_INIT = DIR_RIGHT
) (
    input  logic            clk,
    input  logic            rst_n,
    snake_dir_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] prev_q;
    logic [NUM_BTN-1:0] press_q;

    state_e     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic       dir_chg_q, dir_chg_d;
    logic       start_q, start_d;
    logic       drop_q, drop_d;

    logic       req_vld;
    dir_t       req_dir;
    dir_t       ref_dir;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    dir_t       fifo_head;
    dir_t       fifo_tail;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign level = {bus.middle, bus.up, bus.down, bus.left, bus.right};

    // Press detection; previous levels reset high so held buttons need a release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= '1;
            press_q <= '0;
        end else begin
            prev_q  <= level;
            press_q <= level & ~prev_q;
        end
    end

    // Pick a single direction request; ties resolved up > down > left > right.
    always_comb begin
        req_vld = |press_q[BTN_UP:BTN_RIGHT];
        req_dir = DIR_RIGHT;
        if (press_q[BTN_UP])        req_dir = DIR_UP;
        else if (press_q[BTN_DOWN]) req_dir = DIR_DOWN;
        else if (press_q[BTN_LEFT]) req_dir = DIR_LEFT;
        ref_dir = fifo_empty ? dir_q : fifo_tail;
    end

    // Next state, queue control and output pulses.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dir_chg_d  = 1'b0;
        start_d    = 1'b0;
        drop_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (bus.game_over) begin
            state_d    = ST_IDLE;
            dir_d      = DIR_INIT;
            fifo_flush = 1'b1;
        end else begin
            if (state_q == ST_RUN && bus.step && !fifo_empty) begin
                fifo_pop  = 1'b1;
                dir_d     = fifo_head;
                dir_chg_d = 1'b1;
            end
            // Reference is the pre-pop tail, so a same-cycle pop does not shift it.
            if (state_q == ST_RUN && req_vld) begin
                if (req_dir == ref_dir || req_dir == opposite(ref_dir)) begin
                    drop_d = 1'b1;
                end else if (fifo_full && !fifo_pop) begin
                    drop_d = 1'b1;
                end else begin
                    fifo_push = 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (press_q[BTN_MID]) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (press_q[BTN_MID]) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (press_q[BTN_MID]) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, direction and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_INIT;
            dir_chg_q <= 1'b0;
            start_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            dir_chg_q <= dir_chg_d;
            start_q   <= start_d;
            drop_q    <= drop_d;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_dir_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (req_dir),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .tail_o      (fifo_tail),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.dir     = dir_q;
    assign bus.dir_chg = dir_chg_q;
    assign bus.start   = start_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.paused  = (state_q == ST_PAUSE);
    assign bus.q_count = fifo_count;
    assign bus.drop    = drop_q;

`ifdef SNAKE_DIR_TURBO_EN
    logic [TURBO_W-1:0] turbo_cnt_q;
    logic               dir_held;

    // Level of the button that matches the current direction.
    always_comb begin
        dir_held = 1'b0;
        case (dir_q)
            DIR_UP:   dir_held = bus.up;
            DIR_DOWN: dir_held = bus.down;
            DIR_LEFT: dir_held = bus.left;
            default:  dir_held = bus.right;
        endcase
    end

    // Saturating hold counter, cleared on release, turn or leaving RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turbo_cnt_q <= '0;
        end else if (state_q != ST_RUN || !dir_held || dir_d != dir_q) begin
            turbo_cnt_q <= '0;
        end else if (turbo_cnt_q != '1) begin
            turbo_cnt_q <= turbo_cnt_q + TURBO_W'(1);
        end
    end

    assign bus.turbo = (state_q == ST_RUN) && dir_held && (turbo_cnt_q == '1);
`endif

endmodule
